// File: rtl/mesh_router_pkg.sv
// Shared types and constants for the XY mesh router: port indices, route
// directions and the packet format exchanged between tiles.
package mesh_router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int COORD_W   = 4;
    localparam int DATA_W    = 16;
    localparam int CTRL_W    = 2;
    localparam int MESH_W    = 4;
    localparam int MESH_H    = 4;

    typedef logic [2:0] port_idx_t;

    localparam port_idx_t PORT_LOCAL = 3'd0;
    localparam port_idx_t PORT_N     = 3'd1;
    localparam port_idx_t PORT_E     = 3'd2;
    localparam port_idx_t PORT_S     = 3'd3;
    localparam port_idx_t PORT_W     = 3'd4;

    // Encodings line up with the port indices so a direction maps straight to an output.
    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_N     = 3'd1,
        DIR_E     = 3'd2,
        DIR_S     = 3'd3,
        DIR_W     = 3'd4
    } dir_t;

    localparam logic [CTRL_W-1:0] CTRL_DATA = 2'd0;
    localparam logic [CTRL_W-1:0] CTRL_DONE = 2'd1;

    typedef struct packed {
        logic [CTRL_W-1:0]  ctrl;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [DATA_W-1:0]  data;
    } pkt_t;

    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == PORT_W) ? PORT_LOCAL : p + 3'd1;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Input buffer for one router port: circular storage with read/write
// pointers and an occupancy count; the head is visible the cycle after a push.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (!full) else $error("router_fifo: push while full");
        end
    end
`endif

endmodule

// File: rtl/mesh_router.sv
// Five-port dimension-ordered (X then Y) mesh router with per-input FIFOs
// and per-output round-robin arbitration that locks onto a stalled grant.
module mesh_router
    import mesh_router_pkg::*;
#(
    parameter int X_POS      = 0,
    parameter int Y_POS      = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] in_valid,
    output logic [NUM_PORTS-1:0] in_ready,
    input  pkt_t                 in_pkt    [NUM_PORTS],
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output pkt_t                 out_pkt   [NUM_PORTS]
);

    localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_POS);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_POS);

    logic [NUM_PORTS-1:0] fifo_push;
    logic [NUM_PORTS-1:0] fifo_pop;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    pkt_t                 fifo_head [NUM_PORTS];

    dir_t                 head_dir  [NUM_PORTS];
    logic [NUM_PORTS-1:0] req       [NUM_PORTS];
    port_idx_t            grant     [NUM_PORTS];
    logic [NUM_PORTS-1:0] xfer;

    port_idx_t            rr_ptr    [NUM_PORTS];
    port_idx_t            lock_idx  [NUM_PORTS];
    logic [NUM_PORTS-1:0] lock;

    function automatic dir_t route_of(input pkt_t p);
        dir_t d;
        if (p.x > MY_X)      d = DIR_E;
        else if (p.x < MY_X) d = DIR_W;
        else if (p.y > MY_Y) d = DIR_N;
        else if (p.y < MY_Y) d = DIR_S;
        else                 d = DIR_LOCAL;
        return d;
    endfunction

    function automatic port_idx_t rr_pick(input logic [NUM_PORTS-1:0] r, input port_idx_t ptr);
        port_idx_t idx;
        port_idx_t pick;
        logic      found;
        idx   = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_port(idx);
        end
        return pick;
    endfunction

    // Input stage: FIFO per port, ready purely from occupancy
    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & ~fifo_full;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        router_fifo #(
            .WIDTH ($bits(pkt_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[i]),
            .din   (in_pkt[i]),
            .full  (fifo_full[i]),
            .pop   (fifo_pop[i]),
            .empty (fifo_empty[i]),
            .head  (fifo_head[i])
        );
    end

    // Route stage: each non-empty head requests exactly one output
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            head_dir[i] = route_of(fifo_head[i]);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = ~fifo_empty[i] & (port_idx_t'(head_dir[i]) == 3'(o));
            end
        end
    end

    // Arbitration stage: a held lock overrides the round-robin scan
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant[o]     = lock[o] ? lock_idx[o] : rr_pick(req[o], rr_ptr[o]);
            out_valid[o] = lock[o] | (|req[o]);
            out_pkt[o]   = out_valid[o] ? fifo_head[grant[o]] : '0;
            xfer[o]      = out_valid[o] & out_ready[o];
        end
    end

    // A head routes to a single output, so at most one output pops any FIFO.
    always_comb begin
        fifo_pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (xfer[o]) fifo_pop[grant[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                rr_ptr[o]   <= PORT_LOCAL;
                lock_idx[o] <= PORT_LOCAL;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xfer[o]) begin
                    rr_ptr[o] <= next_port(grant[o]);
                    lock[o]   <= 1'b0;
                end else if (out_valid[o]) begin
                    lock[o]     <= 1'b1;
                    lock_idx[o] <= grant[o];
                end
            end
        end
    end

`ifndef SYNTHESIS
    function automatic logic route_exists(input dir_t d);
        logic ok;
        case (d)
            DIR_N:   ok = (Y_POS < MESH_H - 1);
            DIR_E:   ok = (X_POS < MESH_W - 1);
            DIR_S:   ok = (Y_POS > 0);
            DIR_W:   ok = (X_POS > 0);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    logic [NUM_PORTS-1:0] held_stall;
    pkt_t                 held_pkt [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            held_stall <= '0;
        end else begin
            held_stall <= out_valid & ~out_ready;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            held_pkt[o] <= out_pkt[o];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (held_stall[o]) begin
                    assert (out_valid[o] && out_pkt[o] == held_pkt[o])
                        else $error("mesh_router: output %0d changed while stalled", o);
                end
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!fifo_empty[i]) begin
                    assert (route_exists(head_dir[i]))
                        else $error("mesh_router: input %0d routes off the mesh edge", i);
                end
            end
        end
    end
`endif

endmodule

// File: doc/mesh_router.md
Name: mesh_router

Overview:
- Five-port XY-routed mesh router; one instance per (X_POS, Y_POS) tile, directly attached to that tile's bank.
- The LOCAL port connects to the bank's router-side handshake: bank out to router LOCAL in, router LOCAL out to bank in. N/E/S/W connect to neighbouring routers.
- Buffers each input in a small FIFO, computes dimension-ordered routes at the FIFO heads, and arbitrates each output round-robin with grant locking.

Parameters:
- X_POS, 0, column of this tile.
- Y_POS, 0, row of this tile.
- FIFO_DEPTH, 4, entries per input FIFO (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  [NUM_PORTS]  per-input valid; index order LOCAL=0, N=1, E=2, S=3, W=4.
- in_ready  out  [NUM_PORTS]  per-input ready, i.e. the FIFO is not full.
- in_pkt  in  pkt_t[NUM_PORTS]  per-input packet.
- out_valid  out  [NUM_PORTS]  per-output valid.
- out_ready  in  [NUM_PORTS]  per-output ready.
- out_pkt  out  pkt_t[NUM_PORTS]  per-output packet, passed unmodified.

Behaviour:
- Reset values: in_ready=all 1, out_valid=0, out_pkt='0. All FIFOs empty, RR pointers=0, locks clear. Reset mid-operation drops all buffered packets; there is no partial state.
- Input handshake:
  - Transfer occurs when in_valid & in_ready.
  - in_ready depends only on FIFO occupancy, never on in_valid.
  - When a FIFO is full, in_ready=0 even if a dequeue happens in the same cycle; there is no full-bypass.
- Latency: no empty bypass. A packet enqueued in cycle t is eligible at the output in cycle t+1 at the earliest.
- Route computation (combinational, on each non-empty FIFO head):
  - addr.x>X_POS gives E; addr.x<X_POS gives W.
  - Otherwise addr.y>Y_POS gives N; addr.y<Y_POS gives S.
  - Otherwise LOCAL.
  - ctrl (including CTRL_DONE) does not affect routing.
  - LOCAL-to-LOCAL loopback is legal.
- Output arbitration, per output o:
  - Requesters are the inputs whose head routes to o.
  - The winner is the first requester scanning from rr_ptr[o] upward, modulo NUM_PORTS.
  - out_valid[o]=1 if there is any requester (or the lock holds); out_pkt[o]=head of the winner.
  - Dequeue from the winner's FIFO on out_valid[o] & out_ready[o].
  - After a transfer, rr_ptr[o] becomes winner+1 mod NUM_PORTS; otherwise it holds.
- Grant lock:
  - If out_valid[o] & !out_ready[o], set lock[o] and store the winner index.
  - While locked, the grant stays on the stored input, so out_pkt[o] is stable until accepted.
  - The lock clears on transfer.
- Concurrency: each input feeds at most one output per cycle. Up to 5 transfers occur per cycle on disjoint outputs. Each input's FIFO dequeues at most once per cycle; simultaneous enqueue and dequeue on a non-full FIFO is allowed.
- Ordering: FIFO order is preserved per input-output pair.
- Edge of mesh: a route toward a non-existent neighbour is illegal. Simulation asserts on it; RTL still presents the packet on that output port.
- Assertions: out_pkt stable while out_valid & !out_ready; no FIFO overflow.

Decomposition:
- Shared package (parameters):
  - NUM_PORTS=5.
  - Port index constants PORT_LOCAL/N/E/S/W.
  - Enum dir_t.
- pkt_t and CTRL_DONE already live in types.
- Sub-module router_fifo:
  - Parameters: width of pkt_t, DEPTH.
  - Ports: clk, rst, push, full, pop, empty, head.
  - Implementation: pointer-based with a count register.
- The top level holds route compute, per-output arbiters, and lock/pointer registers.

Test Plan (router at (1,1), FIFO_DEPTH=4, all out_ready=1 unless stated):
1. LOCAL in pkt addr (3,1,z=2) at cycle 0 -> out_valid[E]=1 at cycle 1, out_pkt[E] identical to the input, in_ready stays 1.
2. N and W both send addr (1,1) in the same cycle -> out[LOCAL] gives the N packet at t+1 and the W packet at t+2; rr_ptr[LOCAL]=2, then 0 (W+1 wraps to 0).
3. out_ready[E]=0, W streams 6 pkts to (2,0) -> 4 accepted and in_ready[W]=0. Release out_ready -> 6 pkts leave E in send order, out_pkt stable while stalled.
4. E stalled showing a W packet, then a LOCAL pkt to E arrives (higher priority from ptr 0) -> out_pkt[E] stays the W packet until accept; the LOCAL pkt is sent next.
5. Simultaneous traffic: LOCAL to (0,1), E to (1,2), S to (1,1) -> W, N and LOCAL outputs all fire in the same cycle.
6. Fill the N FIFO with 3 pkts, assert rst for 1 cycle -> next cycle all out_valid=0, in_ready=all 1; no stale packet ever emerges.
